// File: rtl/linear_mixer.sv
// linear_mixer
// Slot-rate output mixer that sits after the log-to-linear stage. Each valid
// slot carries a sign-magnitude sample. The mixer converts it to two's
// complement and sums carrier outputs into a melody sum and a rhythm sum over
// an 18-slot frame. At slot 17 both sums are published with a one-cycle strobe.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   li_valid   slot sample present this cycle
//   li_slot    slot index (0..17 valid, 18..31 flagged and ignored)
//   li_sign    sample sign (1 = negative)
//   li_value   sample magnitude 0..511
//   rhythm     rhythm mode enable, sampled per slot
//   mute       forces published sums to zero
//   mo         published melody sum (signed)
//   ro         published rhythm sum (signed)
//   out_valid  one-cycle pulse when mo/ro update
//   seq_err    sticky slot-sequence error flag
//
// Handshake: li_valid qualifies the slot inputs for exactly the cycle it is
// high. There is no back-pressure; every valid cycle is consumed.
module linear_mixer #(
   parameter int MIXW = 14
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   li_valid,
   input  logic [4:0]             li_slot,
   input  logic                   li_sign,
   input  logic [8:0]             li_value,
   input  logic                   rhythm,
   input  logic                   mute,
   output logic signed [MIXW-1:0] mo,
   output logic signed [MIXW-1:0] ro,
   output logic                   out_valid,
   output logic                   seq_err
);

   logic signed [MIXW-1:0] acc_m_q, acc_m_d;
   logic signed [MIXW-1:0] acc_r_q, acc_r_d;
   logic signed [MIXW-1:0] mo_q, mo_d;
   logic signed [MIXW-1:0] ro_q, ro_d;
   logic                   out_valid_q, out_valid_d;
   logic                   seq_err_q, seq_err_d;
   logic [4:0]             exp_q, exp_d;

   logic signed [MIXW-1:0] mag;
   logic signed [MIXW-1:0] s_val;
   logic signed [MIXW-1:0] cm;
   logic signed [MIXW-1:0] cr;
   logic signed [MIXW-1:0] sum_m;
   logic signed [MIXW-1:0] sum_r;
   logic                   in_range;
   logic                   mel_en;
   logic                   rhy_en;

   always_comb begin
      mag      = MIXW'(li_value);
      // Negative zero naturally maps to zero here.
      s_val    = li_sign ? -mag : mag;
      in_range = (li_slot <= 5'd17);
      // Carriers are the odd slots; in rhythm mode channels 6..8 are drums.
      mel_en   = in_range && li_slot[0] && (!rhythm || (li_slot <= 5'd11));
      // Slot 12 is the BD modulator and contributes nothing.
      rhy_en   = rhythm && in_range && (li_slot >= 5'd13);
      cm       = mel_en ? s_val : '0;
      cr       = rhy_en ? (s_val <<< 1) : '0;
      // Slot 0 starts a fresh frame: load rather than add.
      sum_m    = (li_slot == 5'd0) ? cm : (acc_m_q + cm);
      sum_r    = (li_slot == 5'd0) ? cr : (acc_r_q + cr);
   end

   always_comb begin
      acc_m_d     = acc_m_q;
      acc_r_d     = acc_r_q;
      mo_d        = mo_q;
      ro_d        = ro_q;
      out_valid_d = 1'b0;
      seq_err_d   = seq_err_q;
      exp_d       = exp_q;
      if (li_valid) begin
         if (!in_range) begin
            seq_err_d = 1'b1;
         end else begin
            acc_m_d = sum_m;
            acc_r_d = sum_r;
            exp_d   = (li_slot == 5'd17) ? 5'd0 : (li_slot + 5'd1);
            // Slot 0 always resynchronises and is never an error.
            if ((li_slot != 5'd0) && (li_slot != exp_q)) begin
               seq_err_d = 1'b1;
            end
            if (li_slot == 5'd17) begin
               out_valid_d = 1'b1;
               mo_d        = mute ? '0 : sum_m;
               ro_d        = mute ? '0 : sum_r;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_m_q     <= '0;
         acc_r_q     <= '0;
         mo_q        <= '0;
         ro_q        <= '0;
         out_valid_q <= 1'b0;
         seq_err_q   <= 1'b0;
         exp_q       <= 5'd0;
      end else begin
         acc_m_q     <= acc_m_d;
         acc_r_q     <= acc_r_d;
         mo_q        <= mo_d;
         ro_q        <= ro_d;
         out_valid_q <= out_valid_d;
         seq_err_q   <= seq_err_d;
         exp_q       <= exp_d;
      end
   end

   assign mo        = mo_q;
   assign ro        = ro_q;
   assign out_valid = out_valid_q;
   assign seq_err   = seq_err_q;

endmodule

// File: doc/linear_mixer.md
# linear_mixer

Slot-rate output mixer placed directly downstream of the log-to-linear stage in the VM2413 operator pipeline. It takes one sign-magnitude linear sample per operator slot, converts each to two's complement, and accumulates carrier outputs into a melody sum and a rhythm sum over each 18-slot frame. At frame end it presents both sums as registered signed samples with a one-cycle valid strobe. It also flags slot-sequence errors from the upstream slot counter.

## Interface
- `MIXW`, default 14: width of the signed melody and rhythm outputs; values below 14 are unsupported.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `li_valid`  in  1  a slot sample is present this cycle.
- `li_slot`  in  5  slot index 0..17; slot = 2*channel + op, where op=1 is the carrier.
- `li_sign`  in  1  sign of the sample (1 = negative).
- `li_value`  in  9  magnitude of the sample, unsigned 0..511.
- `rhythm`  in  1  rhythm mode enable; sampled per slot.
- `mute`  in  1  forces the published outputs to zero.
- `mo`  out  MIXW  melody sum, signed two's complement.
- `ro`  out  MIXW  rhythm sum, signed two's complement.
- `out_valid`  out  1  one-cycle pulse when `mo`/`ro` update.
- `seq_err`  out  1  sticky slot-sequence error flag.

## Operation
- Conversion: `s = li_sign ? -li_value : +li_value`, sign-extended to MIXW. Sign=1 with value 0 gives 0.
- Melody contribution, for odd slots only:
  - `rhythm=0`: slots 1,3,…,17 contribute `s`.
  - `rhythm=1`: slots 1,3,…,11 contribute `s`.
- Rhythm contribution, only when `rhythm=1`: slots 13 (BD), 14 (HH), 15 (SD), 16 (TOM) and 17 (CYM) each contribute `2*s`. Slot 12 contributes nothing.
- Any contribution not listed above is 0. Slots 18..31 are ignored entirely: no accumulation and no counter change. They do set `seq_err`.
- Accumulators `acc_m` and `acc_r` are MIXW bits wide:
  - On a valid slot 0, both are loaded with that slot's contribution; they are not added to.
  - On other valid slots in 1..17, each accumulator adds its contribution.
- Range: |melody| ≤ 9·511 = 4599 and |rhythm| ≤ 5·1022 = 5110, both within ±8191, so no saturation is needed.
- Frame end is a valid slot 17:
  - `mo` is set to `acc_m` plus this slot's melody contribution; `ro` is set likewise from `acc_r`.
  - `out_valid` is set to 1 for exactly one cycle.
  - If `mute=1`, `mo` and `ro` are written 0 instead; `out_valid` still pulses.
- Frames with missing slots still publish at slot 17. The accumulators then hold whatever was summed since the last slot 0.
- Sequence check:
  - An internal expected-slot counter `exp` (5 bits) advances on every valid slot in 0..17: to 0 after 17, otherwise to slot+1.
  - A valid slot 0 always resynchronises `exp` to 1 and is never an error.
  - A valid slot in 1..17 that differs from `exp` sets `seq_err`. Accumulation proceeds anyway, and `exp` follows slot+1.
  - `seq_err` stays set until reset.
- When `li_valid=0`, no state changes except that `out_valid` falls.

## Timing
- Reset (asynchronous assert, synchronous-safe release) clears `mo`, `ro`, `out_valid`, `seq_err`, `acc_m`, `acc_r` and `exp` to 0. The first frame expects slot 0.
- Throughput: one slot per cycle; back-to-back `li_valid` is allowed. Gaps of any length between slots are allowed.
- Latency: `mo`/`ro`/`out_valid` update on the clock edge that samples slot 17, so they are visible the cycle after slot 17 is presented.
- `mo`/`ro` hold their value between frame ends.
- A slot 0 presented the cycle after slot 17 is accepted normally. The published outputs are unaffected by it.
- Reset asserted mid-frame discards the partial sums. Outputs read 0 until the next complete slot 17.
- `seq_err` updates on the edge that samples the offending slot.

## Test plan
- Reset then idle. Required: `mo=ro=0`, `out_valid=0`, `seq_err=0`.
- Melody full scale. Stimulus: `rhythm=0`, slots 0..17 back-to-back, every odd slot +511, every even slot +300. Required: `mo=4599`, `ro=0`, a single `out_valid` pulse one cycle after slot 17, `seq_err=0`.
- Rhythm mode. Stimulus: `rhythm=1`, odd slots 1..11 = −100, slot 12 = +400, slots 13..17 = +10. Required: `mo=−600`, `ro=100`.
- Mute and negative zero. Stimulus: a frame with `mute=1` and all slots +511. Required: `mo=ro=0` with an `out_valid` pulse. Then a frame with every slot sign=1, value=0. Required: `mo=ro=0`.
- Sequence error. Stimulus: slots 0,1,2,4,5..17. Required: `seq_err` rises on the edge that samples slot 4 and the frame still publishes. Then a clean frame: `seq_err` stays 1. Then reset: `seq_err=0`.
- Reset mid-frame. Stimulus: assert `reset` low after slot 9 with a nonzero partial sum, release, then a clean frame with odd slots = +1. Required: `mo=9` and no contribution from the aborted frame.
